// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory bus. It grants one access per
// cycle, either round-robin or with fixed priority to m0. Read responses are
// routed back to the master that issued the read. A master can lock the bus
// for atomic sequences, but only for a bounded number of cycles.
module mem_bus_arbiter #(
   parameter int FIXED_PRIORITY  = 0,
   parameter int MAX_LOCK_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_write_data,
   input  logic [3:0]  m0_byte_enable,
   input  logic        m0_read_enable,
   input  logic        m0_write_enable,
   input  logic        m0_lock,
   output logic        m0_ready,
   output logic [31:0] m0_read_data,
   output logic        m0_read_valid,
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_write_data,
   input  logic [3:0]  m1_byte_enable,
   input  logic        m1_read_enable,
   input  logic        m1_write_enable,
   input  logic        m1_lock,
   output logic        m1_ready,
   output logic [31:0] m1_read_data,
   output logic        m1_read_valid,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_byte_enable,
   output logic        bus_read_enable,
   output logic        bus_write_enable,
   input  logic [31:0] bus_read_data
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

   localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK_CYCLES);

   lock_state_t state, state_nxt;
   logic [7:0]  lock_count, count_nxt, count_inc;
   logic        lock_owner, owner_nxt;
   logic        last_grant, last_nxt;
   // One-cycle flag after a forced unlock. While it is set, a tie is broken
   // by last_grant even under fixed priority, so the stalled master gets in.
   logic        post_lock, post_nxt;
   logic        rd_pending, rd_owner;

   logic req0, req1, grant0, grant1;
   logic any_grant, grant_sel, grant_lock, grant_read;

   // A write wins over a read when a master raises both enables.
   assign req0       = m0_read_enable | m0_write_enable;
   assign req1       = m1_read_enable | m1_write_enable;
   assign any_grant  = grant0 | grant1;
   assign grant_sel  = grant1;
   assign grant_lock = grant1 ? m1_lock : m0_lock;
   assign grant_read = grant1 ? (m1_read_enable & ~m1_write_enable)
                              : (grant0 & m0_read_enable & ~m0_write_enable);
   assign count_inc  = (lock_count >= MAX_CNT) ? MAX_CNT : lock_count + 8'd1;

   assign m0_ready      = grant0;
   assign m1_ready      = grant1;
   assign m0_read_data  = bus_read_data;
   assign m1_read_data  = bus_read_data;
   assign m0_read_valid = ~reset & rd_pending & ~rd_owner;
   assign m1_read_valid = ~reset & rd_pending & rd_owner;

   // Lock state, arbitration history and counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= UNLOCKED;
         lock_count <= 8'd0;
         lock_owner <= 1'b0;
         last_grant <= 1'b1;
         post_lock  <= 1'b0;
      end else begin
         state      <= state_nxt;
         lock_count <= count_nxt;
         lock_owner <= owner_nxt;
         last_grant <= last_nxt;
         post_lock  <= post_nxt;
      end
   end

   // Read response tracking: the owner of a granted read gets the strobe next cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pending <= grant_read;
         rd_owner   <= grant_sel;
      end
   end

   // Next-state logic for the lock FSM and the grant history
   always_comb begin
      state_nxt = state;
      count_nxt = lock_count;
      owner_nxt = lock_owner;
      post_nxt  = 1'b0;
      last_nxt  = any_grant ? grant_sel : last_grant;
      case (state)
         UNLOCKED: begin
            if (any_grant && grant_lock) begin
               if (MAX_CNT > 8'd1) begin
                  state_nxt = LOCKED;
                  owner_nxt = grant_sel;
                  count_nxt = 8'd1;
               end else begin
                  // A one-cycle budget is used up by this very grant.
                  post_nxt = 1'b1;
               end
            end
         end
         LOCKED: begin
            // Only the owner can hold a grant here.
            if (any_grant && !grant_lock) begin
               state_nxt = UNLOCKED;
               count_nxt = 8'd0;
            end else begin
               count_nxt = count_inc;
               if (count_inc >= MAX_CNT) begin
                  state_nxt = UNLOCKED;
                  post_nxt  = 1'b1;
                  last_nxt  = lock_owner;
               end
            end
         end
         default: state_nxt = UNLOCKED;
      endcase
   end

   // Grant selection and bus mux
   always_comb begin
      grant0           = 1'b0;
      grant1           = 1'b0;
      bus_address      = 32'd0;
      bus_write_data   = 32'd0;
      bus_byte_enable  = 4'd0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      if (!reset) begin
         if (state == LOCKED) begin
            grant0 = req0 & ~lock_owner;
            grant1 = req1 & lock_owner;
         end else if (req0 && req1) begin
            if (FIXED_PRIORITY != 0 && !post_lock) begin
               grant0 = 1'b1;
            end else begin
               grant0 = last_grant;
               grant1 = ~last_grant;
            end
         end else begin
            grant0 = req0;
            grant1 = req1;
         end
      end
      if (grant0) begin
         bus_address      = m0_address;
         bus_write_data   = m0_write_data;
         bus_byte_enable  = m0_byte_enable;
         bus_read_enable  = m0_read_enable & ~m0_write_enable;
         bus_write_enable = m0_write_enable;
      end else if (grant1) begin
         bus_address      = m1_address;
         bus_write_data   = m1_write_data;
         bus_byte_enable  = m1_byte_enable;
         bus_read_enable  = m1_read_enable & ~m1_write_enable;
         bus_write_enable = m1_write_enable;
      end
   end

endmodule
